// File: rtl/eth_phy_pkg.sv
// Shared constants and types for the 10G PHY TX path.
// Block/word geometry, sync headers and the gearbox controller state encoding.
package eth_phy_pkg;

  localparam int BLOCK_W    = 66;
  localparam int WORD_W     = 64;
  localparam int HDR_W      = 2;
  localparam int GB_SEQ_LEN = 33;
  localparam int BUF_W      = 128;
  localparam int FILL_W     = 7;

  localparam logic [1:0] SYNC_DATA = 2'b10;
  localparam logic [1:0] SYNC_CTRL = 2'b01;

  // GB_IDLE: no word emitted since reset; GB_RUN: streaming has started.
  typedef enum logic {
    GB_IDLE = 1'b0,
    GB_RUN  = 1'b1
  } gb_state_t;

  // Bit count after an optional 66-bit insert; 8 bits because 62 + 66 = 128.
  function automatic logic [FILL_W:0] fill_after_insert(input logic [FILL_W-1:0] fill,
                                                        input logic accept);
    logic [FILL_W:0] add;
    add = accept ? (FILL_W+1)'(BLOCK_W) : '0;
    return {1'b0, fill} + add;
  endfunction

endpackage

// File: rtl/eth_gearbox_buf.sv
// 128-bit gearbox bit buffer: variable-offset 66-bit insert, fixed 64-bit drain.
// LSB holds the oldest bit; bits at and above the fill offset are always zero.
module eth_gearbox_buf
  import eth_phy_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                insert_en,
  input  logic [FILL_W-1:0]   insert_off,
  input  logic [BLOCK_W-1:0]  insert_blk,
  input  logic                drain_en,
  output logic [WORD_W-1:0]   head
);

  logic [BUF_W-1:0] bit_buf;
  logic [BUF_W-1:0] merged;
  logic [BUF_W-1:0] blk_wide;

  assign blk_wide = {{(BUF_W-BLOCK_W){1'b0}}, insert_blk};

  // OR-insert is safe because everything above the offset is already zero.
  always_comb begin
    merged = bit_buf;
    if (insert_en) begin
      merged = bit_buf | (blk_wide << insert_off);
    end
  end

  assign head = merged[WORD_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_buf <= '0;
    end else if (drain_en) begin
      bit_buf <= {{WORD_W{1'b0}}, merged[BUF_W-1:WORD_W]};
    end else begin
      bit_buf <= merged;
    end
  end

endmodule

// File: rtl/eth_phy_10g_tx_gearbox.sv
// TX 66b->64b gearbox: accepts {in_data, in_hdr} blocks at up to 32 per 33 cycles
// and emits one 64-bit SERDES word whenever at least 64 bits are buffered.
module eth_phy_10g_tx_gearbox
  import eth_phy_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int HDR_WIDTH  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [HDR_WIDTH-1:0]  in_hdr,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] serdes_tx_data,
  output logic                  serdes_tx_valid,
  output logic                  tx_underflow
);

  if (DATA_WIDTH != WORD_W) begin : g_bad_data_width
    $error("eth_phy_10g_tx_gearbox: DATA_WIDTH must be 64");
  end
  if (HDR_WIDTH != HDR_W) begin : g_bad_hdr_width
    $error("eth_phy_10g_tx_gearbox: HDR_WIDTH must be 2");
  end

  // Handshake: a block transfers on a rising edge where in_valid && in_ready;
  // in_ready is registered and never depends on in_valid in the same cycle.

  logic                accept;
  logic [FILL_W:0]     fill_sum;
  logic                emit;
  logic [FILL_W-1:0]   fill_q;
  logic [FILL_W-1:0]   fill_next;
  logic [WORD_W-1:0]   head;
  gb_state_t           state_q;
  gb_state_t           state_next;
  logic                started;

  assign accept    = in_valid && in_ready;
  assign fill_sum  = fill_after_insert(fill_q, accept);
  assign emit      = (fill_sum >= (FILL_W+1)'(WORD_W));
  assign fill_next = emit ? FILL_W'(fill_sum - (FILL_W+1)'(WORD_W)) : fill_sum[FILL_W-1:0];

  eth_gearbox_buf u_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .insert_en  (accept),
    .insert_off (fill_q),
    .insert_blk ({in_data, in_hdr}),
    .drain_en   (emit),
    .head       (head)
  );

  // Streaming-state FSM: state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= GB_IDLE;
    end else begin
      state_q <= state_next;
    end
  end

  // Streaming-state FSM: next state. Only reset leaves GB_RUN.
  always_comb begin
    state_next = state_q;
    case (state_q)
      GB_IDLE: if (emit) state_next = GB_RUN;
      GB_RUN:  state_next = GB_RUN;
      default: state_next = GB_IDLE;
    endcase
  end

  // Streaming-state FSM: outputs.
  always_comb begin
    started = 1'b0;
    case (state_q)
      GB_RUN:  started = 1'b1;
      default: started = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_q          <= '0;
      in_ready        <= 1'b0;
      serdes_tx_data  <= '0;
      serdes_tx_valid <= 1'b0;
      tx_underflow    <= 1'b0;
    end else begin
      fill_q          <= fill_next;
      in_ready        <= (fill_next < FILL_W'(WORD_W));
      serdes_tx_valid <= emit;
      // An empty slot only counts as underflow once a word has gone out.
      tx_underflow    <= started && !emit;
      if (emit) begin
        serdes_tx_data <= head;
      end
    end
  end

endmodule
